// File: rtl/sw_debounce_if.sv
// Switch debounce bundle: raw switches in, debounced levels and edge
// pulses out.
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             any_chg;
  logic [7:0]       chg_cnt;

  modport master (
    output sw,
    input  sw_db,
    input  rise,
    input  fall,
    input  any_chg,
    input  chg_cnt
  );

  modport slave (
    input  sw,
    output sw_db,
    output rise,
    output fall,
    output any_chg,
    output chg_cnt
  );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for slide switches,
// with registered rise/fall pulses and a wrapping change counter.
module sw_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 100000,
  parameter int CNT_W   = 17
) (
  input logic          clk,
  input logic          rst,
  sw_debounce_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             any_q, any_d;
  logic [7:0]       chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == LAST) begin
          db_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // One increment per cycle, however many bits flipped together
    any_d = |(rise_d | fall_d);
    chg_d = chg_q + {7'd0, any_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      chg_q  <= '0;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= '0;
    end else begin
      s1_q   <= bus.sw;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      chg_q  <= chg_d;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.sw_db   = db_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.any_chg = any_q;
  assign bus.chg_cnt = chg_q;

endmodule
